// File: rtl/lotr_ring_stop_if.sv
// Opcode package and ring-stop bus interface for the LOTR ring.
// The slave modport is the ring stop; the master modport is the tile/ring side.
package lotr_pkg;
  typedef enum logic [1:0] {
    RD      = 2'd0,
    RD_RSP  = 2'd1,
    WR      = 2'd2,
    WR_BCST = 2'd3
  } t_opcode;
endpackage

interface lotr_ring_stop_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import lotr_pkg::*;

  logic              RingInputValidQ500H;
  t_opcode           RingInputOpcodeQ500H;
  logic [ADDR_W-1:0] RingInputAddressQ500H;
  logic [DATA_W-1:0] RingInputDataQ500H;

  logic              RingOutputValidQ502H;
  t_opcode           RingOutputOpcodeQ502H;
  logic [ADDR_W-1:0] RingOutputAddressQ502H;
  logic [DATA_W-1:0] RingOutputDataQ502H;

  logic              LocalReqValidQ502H;
  t_opcode           LocalReqOpcodeQ502H;
  logic [ADDR_W-1:0] LocalReqAddressQ502H;
  logic [DATA_W-1:0] LocalReqDataQ502H;

  logic              LocalInjValid;
  logic              LocalInjReady;
  t_opcode           LocalInjOpcode;
  logic [ADDR_W-1:0] LocalInjAddress;
  logic [DATA_W-1:0] LocalInjData;

  modport master (
    output RingInputValidQ500H, RingInputOpcodeQ500H, RingInputAddressQ500H, RingInputDataQ500H,
    input  RingOutputValidQ502H, RingOutputOpcodeQ502H, RingOutputAddressQ502H, RingOutputDataQ502H,
    input  LocalReqValidQ502H, LocalReqOpcodeQ502H, LocalReqAddressQ502H, LocalReqDataQ502H,
    output LocalInjValid, LocalInjOpcode, LocalInjAddress, LocalInjData,
    input  LocalInjReady
  );

  modport slave (
    input  RingInputValidQ500H, RingInputOpcodeQ500H, RingInputAddressQ500H, RingInputDataQ500H,
    output RingOutputValidQ502H, RingOutputOpcodeQ502H, RingOutputAddressQ502H, RingOutputDataQ502H,
    output LocalReqValidQ502H, LocalReqOpcodeQ502H, LocalReqAddressQ502H, LocalReqDataQ502H,
    input  LocalInjValid, LocalInjOpcode, LocalInjAddress, LocalInjData,
    output LocalInjReady
  );
endinterface

// File: rtl/lotr_ring_stop.sv
// LOTR ring stop: consume/forward/broadcast ring slots and refill empty slots from a local FIFO.
// Optional saturating performance counters are enabled with `define LOTR_RING_STOP_PERF_EN.
module lotr_ring_stop
  import lotr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            QClk,
  input  logic            RstQnnnL,
  input  logic [7:0]      CoreID,
  lotr_ring_stop_if.slave ring,
  output logic [15:0]     PerfFwdCnt,
  output logic [15:0]     PerfConsCnt,
  output logic [15:0]     PerfInjCnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              s1_valid;
  t_opcode           s1_opcode;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      s1_valid  <= 1'b0;
      s1_opcode <= RD;
      s1_addr   <= '0;
      s1_data   <= '0;
    end else begin
      s1_valid  <= ring.RingInputValidQ500H;
      s1_opcode <= ring.RingInputOpcodeQ500H;
      s1_addr   <= ring.RingInputAddressQ500H;
      s1_data   <= ring.RingInputDataQ500H;
    end
  end

  logic [7:0] tgt_id;
  logic [7:0] org_id;
  logic       is_bcst;
  logic       consume;
  logic       bcst_deliver;
  logic       bcst_drop;
  logic       deliver;
  logic       forward;

  assign tgt_id       = s1_addr[31:24];
  assign org_id       = s1_addr[23:16];
  assign is_bcst      = (s1_opcode == WR_BCST);
  assign consume      = s1_valid && !is_bcst && (tgt_id == CoreID);
  assign bcst_deliver = s1_valid && is_bcst && (org_id != CoreID);
  assign bcst_drop    = s1_valid && is_bcst && (org_id == CoreID);
  assign deliver      = consume || bcst_deliver;
  assign forward      = s1_valid && !consume && !bcst_drop;

  t_opcode           fifo_op   [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // count never exceeds DEPTH, so its MSB alone marks the full state
  assign ring.LocalInjReady = !count[PTR_W];
  assign fifo_empty         = (count == '0);
  assign push               = ring.LocalInjValid && ring.LocalInjReady;
  assign pop                = !forward && !fifo_empty;

  always_ff @(posedge QClk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= ring.LocalInjOpcode;
      fifo_addr[wr_ptr] <= ring.LocalInjAddress;
      fifo_data[wr_ptr] <= ring.LocalInjData;
    end
  end

  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  logic              out_valid;
  t_opcode           out_opcode;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              loc_valid;
  t_opcode           loc_opcode;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_data;

  // Ring traffic wins the outgoing slot; the FIFO head only fills a hole.
  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      out_valid  <= 1'b0;
      out_opcode <= RD;
      out_addr   <= '0;
      out_data   <= '0;
      loc_valid  <= 1'b0;
      loc_opcode <= RD;
      loc_addr   <= '0;
      loc_data   <= '0;
    end else begin
      loc_valid  <= deliver;
      loc_opcode <= deliver ? s1_opcode : RD;
      loc_addr   <= deliver ? s1_addr : '0;
      loc_data   <= deliver ? s1_data : '0;
      if (forward) begin
        out_valid  <= 1'b1;
        out_opcode <= s1_opcode;
        out_addr   <= s1_addr;
        out_data   <= s1_data;
      end else if (pop) begin
        out_valid  <= 1'b1;
        out_opcode <= fifo_op[rd_ptr];
        out_addr   <= fifo_addr[rd_ptr];
        out_data   <= fifo_data[rd_ptr];
      end else begin
        out_valid  <= 1'b0;
        out_opcode <= RD;
        out_addr   <= '0;
        out_data   <= '0;
      end
    end
  end

  assign ring.RingOutputValidQ502H   = out_valid;
  assign ring.RingOutputOpcodeQ502H  = out_opcode;
  assign ring.RingOutputAddressQ502H = out_addr;
  assign ring.RingOutputDataQ502H    = out_data;
  assign ring.LocalReqValidQ502H     = loc_valid;
  assign ring.LocalReqOpcodeQ502H    = loc_opcode;
  assign ring.LocalReqAddressQ502H   = loc_addr;
  assign ring.LocalReqDataQ502H      = loc_data;

`ifdef LOTR_RING_STOP_PERF_EN
  logic [15:0] fwd_cnt;
  logic [15:0] cons_cnt;
  logic [15:0] inj_cnt;

  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      fwd_cnt  <= '0;
      cons_cnt <= '0;
      inj_cnt  <= '0;
    end else begin
      if (forward && fwd_cnt != 16'hFFFF)  fwd_cnt  <= fwd_cnt + 16'd1;
      if (deliver && cons_cnt != 16'hFFFF) cons_cnt <= cons_cnt + 16'd1;
      if (pop && inj_cnt != 16'hFFFF)      inj_cnt  <= inj_cnt + 16'd1;
    end
  end

  assign PerfFwdCnt  = fwd_cnt;
  assign PerfConsCnt = cons_cnt;
  assign PerfInjCnt  = inj_cnt;
`else
  assign PerfFwdCnt  = '0;
  assign PerfConsCnt = '0;
  assign PerfInjCnt  = '0;
`endif

endmodule
